// File: rtl/run_sequencer.sv
// rtl/run_sequencer.sv - steps a DUT through a range of programs, timing each run.
module run_sequencer #(
    parameter int NUM_PROGS  = 3,
    parameter int RST_CYCLES = 2,
    parameter int TIMEOUT    = 4095,
    parameter int CNT_W      = 16,
    localparam int SEL_W     = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [SEL_W-1:0] prog_first,
    input  logic [SEL_W-1:0] prog_last,
    input  logic             dut_done,
    output logic             dut_reset,
    output logic [SEL_W-1:0] prog_sel,
    output logic             busy,
    output logic             res_valid,
    output logic [SEL_W-1:0] res_prog,
    output logic [CNT_W-1:0] res_cycles,
    output logic             res_timeout,
    output logic [NUM_PROGS-1:0] fail_mask,
    output logic             all_done,
    output logic             cfg_err
);
    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, RST, RUN, NEXT} state_t;

    state_t           state, state_nx;
    logic [SEL_W-1:0] last_q;
    logic [RW-1:0]    rst_cnt;
    logic [CNT_W-1:0] cnt;
    logic             range_ok;
    logic             rst_end;
    logic             cnt_max;

    assign range_ok = (prog_first <= prog_last) && (32'(prog_last) < 32'(NUM_PROGS));
    assign rst_end  = (rst_cnt == RW'(RST_CYCLES - 1));
    assign cnt_max  = (cnt == CNT_W'(TIMEOUT));

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start && !abort && range_ok) state_nx = RST;
            RST:  if (abort) state_nx = IDLE;
                  else if (rst_end) state_nx = RUN;
            RUN:  if (abort) state_nx = IDLE;
                  else if (dut_done || cnt_max) state_nx = NEXT;
            NEXT: if (abort || prog_sel == last_q) state_nx = IDLE;
                  else state_nx = RST;
            default: state_nx = IDLE;
        endcase
    end

    // The result pulse is suppressed combinationally so an abort or reset in NEXT wins.
    assign dut_reset = (state != RUN);
    assign res_valid = (state == NEXT) && !abort && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            last_q      <= '0;
            rst_cnt     <= '0;
            cnt         <= '0;
            prog_sel    <= '0;
            busy        <= 1'b0;
            res_prog    <= '0;
            res_cycles  <= '0;
            res_timeout <= 1'b0;
            fail_mask   <= '0;
            all_done    <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            state   <= state_nx;
            cfg_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        if (range_ok) begin
                            last_q    <= prog_last;
                            prog_sel  <= prog_first;
                            fail_mask <= '0;
                            all_done  <= 1'b0;
                            busy      <= 1'b1;
                            rst_cnt   <= '0;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                RST: begin
                    if (abort) begin
                        busy <= 1'b0;
                    end else begin
                        rst_cnt <= rst_cnt + RW'(1);
                        cnt     <= '0;
                    end
                end
                RUN: begin
                    if (abort) begin
                        busy <= 1'b0;
                    end else if (dut_done) begin
                        res_prog    <= prog_sel;
                        res_cycles  <= cnt;
                        res_timeout <= 1'b0;
                    end else if (cnt_max) begin
                        res_prog            <= prog_sel;
                        res_cycles          <= CNT_W'(TIMEOUT);
                        res_timeout         <= 1'b1;
                        fail_mask[prog_sel] <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                NEXT: begin
                    if (abort) begin
                        busy <= 1'b0;
                    end else if (prog_sel == last_q) begin
                        busy     <= 1'b0;
                        all_done <= 1'b1;
                    end else begin
                        prog_sel <= prog_sel + SEL_W'(1);
                        rst_cnt  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_run_sequencer.sv
// tb/tb_run_sequencer.sv - directed self-checking bench for run_sequencer.
module tb_run_sequencer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [1:0] prog_first = '0;
    logic [1:0] prog_last = '0;
    logic       dut_done = 1'b0;
    logic       use_b = 1'b0;

    logic        a_dut_reset, a_busy, a_res_valid, a_res_timeout, a_all_done, a_cfg_err;
    logic [1:0]  a_prog_sel, a_res_prog;
    logic [15:0] a_res_cycles;
    logic [2:0]  a_fail_mask;
    logic        b_dut_reset, b_busy, b_res_valid, b_res_timeout, b_all_done, b_cfg_err;
    logic [1:0]  b_prog_sel, b_res_prog;
    logic [15:0] b_res_cycles;
    logic [2:0]  b_fail_mask;

    always #5 clk = ~clk;

    run_sequencer dut_a (
        .clk(clk), .reset(reset), .start(start && !use_b), .abort(abort),
        .prog_first(prog_first), .prog_last(prog_last), .dut_done(dut_done),
        .dut_reset(a_dut_reset), .prog_sel(a_prog_sel), .busy(a_busy),
        .res_valid(a_res_valid), .res_prog(a_res_prog), .res_cycles(a_res_cycles),
        .res_timeout(a_res_timeout), .fail_mask(a_fail_mask), .all_done(a_all_done),
        .cfg_err(a_cfg_err)
    );

    run_sequencer #(.TIMEOUT(8)) dut_b (
        .clk(clk), .reset(reset), .start(start && use_b), .abort(abort),
        .prog_first(prog_first), .prog_last(prog_last), .dut_done(dut_done),
        .dut_reset(b_dut_reset), .prog_sel(b_prog_sel), .busy(b_busy),
        .res_valid(b_res_valid), .res_prog(b_res_prog), .res_cycles(b_res_cycles),
        .res_timeout(b_res_timeout), .fail_mask(b_fail_mask), .all_done(b_all_done),
        .cfg_err(b_cfg_err)
    );

    wire        m_dut_reset   = use_b ? b_dut_reset : a_dut_reset;
    wire        m_busy        = use_b ? b_busy : a_busy;
    wire        m_res_valid   = use_b ? b_res_valid : a_res_valid;
    wire        m_res_timeout = use_b ? b_res_timeout : a_res_timeout;
    wire        m_all_done    = use_b ? b_all_done : a_all_done;
    wire        m_cfg_err     = use_b ? b_cfg_err : a_cfg_err;
    wire [1:0]  m_prog_sel    = use_b ? b_prog_sel : a_prog_sel;
    wire [1:0]  m_res_prog    = use_b ? b_res_prog : a_res_prog;
    wire [15:0] m_res_cycles  = use_b ? b_res_cycles : a_res_cycles;
    wire [2:0]  m_fail_mask   = use_b ? b_fail_mask : a_fail_mask;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // DUT model: asserts dut_done when its RUN-cycle count reaches tgt[prog_sel]; -1 never.
    int tgt[4];
    int run_cyc = 0;
    logic done_force = 1'b0;
    always @(negedge clk) begin
        if (m_dut_reset) begin
            run_cyc  = 0;
            dut_done = done_force;
        end else begin
            dut_done = (tgt[m_prog_sel] >= 0) && (run_cyc == tgt[m_prog_sel]);
            run_cyc++;
        end
    end

    int qp[$];
    int qc[$];
    int qt[$];
    int rq[$];
    int rst_run = 0;
    int bad_run = 0;
    always @(negedge clk) begin
        if (m_res_valid) begin
            qp.push_back(int'(m_res_prog));
            qc.push_back(int'(m_res_cycles));
            qt.push_back(int'(m_res_timeout));
        end
        if (m_busy && m_dut_reset && !m_res_valid) begin
            rst_run++;
        end else begin
            if (rst_run > 0) rq.push_back(rst_run);
            rst_run = 0;
        end
        if (!m_dut_reset && !m_busy) bad_run++;
    end

    task automatic clear_q();
        qp.delete(); qc.delete(); qt.delete(); rq.delete();
    endtask

    task automatic pulse_start(input logic [1:0] f, input logic [1:0] l);
        @(posedge clk); #1;
        start = 1'b1; prog_first = f; prog_last = l;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while (m_busy && n < max) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle", 32'(m_busy), 32'd0);
    endtask

    task automatic check_res(input int i, input int p, input int c, input int t);
        if (qp.size() > i) begin
            check($sformatf("res%0d_prog", i), qp[i], p);
            check($sformatf("res%0d_cycles", i), qc[i], c);
            check($sformatf("res%0d_timeout", i), qt[i], t);
        end else begin
            check($sformatf("res%0d_present", i), qp.size(), i + 1);
        end
    endtask

    initial begin
        int n;
        tgt = '{-1, -1, -1, -1};
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_dut_reset", m_dut_reset, 1);
        check("rst_prog_sel", m_prog_sel, 0);
        check("rst_busy", m_busy, 0);
        check("rst_res_valid", m_res_valid, 0);
        check("rst_res_cycles", m_res_cycles, 0);
        check("rst_fail_mask", m_fail_mask, 0);
        check("rst_all_done", m_all_done, 0);
        check("rst_cfg_err", m_cfg_err, 0);

        // full sequence 0..2
        tgt = '{5, 9, 0, -1};
        clear_q();
        pulse_start(2'd0, 2'd2);
        @(negedge clk);
        check("seq_busy", m_busy, 1);
        wait_idle(200);
        check("seq_count", qp.size(), 3);
        check_res(0, 0, 5, 0);
        check_res(1, 1, 9, 0);
        check_res(2, 2, 0, 0);
        check("seq_rst_runs", rq.size(), 3);
        foreach (rq[i]) check($sformatf("seq_rst_len%0d", i), rq[i], 2);
        check("seq_all_done", m_all_done, 1);
        check("seq_fail_mask", m_fail_mask, 0);

        // illegal ranges
        pulse_start(2'd2, 2'd1);
        @(negedge clk);
        check("ill1_cfg_err", m_cfg_err, 1);
        check("ill1_busy", m_busy, 0);
        check("ill1_all_done_kept", m_all_done, 1);
        @(negedge clk);
        check("ill1_cfg_err_drop", m_cfg_err, 0);
        pulse_start(2'd0, 2'd3);
        @(negedge clk);
        check("ill2_cfg_err", m_cfg_err, 1);
        check("ill2_busy", m_busy, 0);
        @(negedge clk);
        check("ill2_cfg_err_drop", m_cfg_err, 0);

        // abort in RUN of program 1
        tgt = '{2, 30, 3, -1};
        clear_q();
        pulse_start(2'd0, 2'd2);
        n = 0;
        while (!(m_prog_sel == 2'd1 && !m_dut_reset) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("abort_reach_run1", n < 100, 1);
        repeat (3) @(negedge clk);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        check("abort_dut_reset", m_dut_reset, 1);
        check("abort_busy", m_busy, 0);
        check("abort_all_done", m_all_done, 0);
        repeat (3) @(negedge clk);
        check("abort_count", qp.size(), 1);
        check_res(0, 0, 2, 0);

        // reset during RST of program 2
        tgt = '{1, 1, 4, -1};
        clear_q();
        pulse_start(2'd0, 2'd2);
        n = 0;
        while (!(m_prog_sel == 2'd2 && m_busy && m_dut_reset && !m_res_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rst2_reach", n < 100, 1);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("rst2_dut_reset", m_dut_reset, 1);
        check("rst2_prog_sel", m_prog_sel, 0);
        check("rst2_busy", m_busy, 0);
        check("rst2_res_cycles", m_res_cycles, 0);
        check("rst2_res_prog", m_res_prog, 0);
        check("rst2_count", qp.size(), 2);
        clear_q();
        pulse_start(2'd2, 2'd2);
        wait_idle(100);
        check("rst2_after_count", qp.size(), 1);
        check_res(0, 2, 4, 0);

        // dut_done held through RST, start during RUN
        tgt = '{7, -1, -1, -1};
        clear_q();
        done_force = 1'b1;
        pulse_start(2'd0, 2'd0);
        n = 0;
        while (m_dut_reset && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ign_reach_run", n < 50, 1);
        done_force = 1'b0;
        pulse_start(2'd1, 2'd2);
        wait_idle(100);
        check("ign_count", qp.size(), 1);
        check_res(0, 0, 7, 0);
        check("ign_prog_sel", m_prog_sel, 0);
        check("ign_all_done", m_all_done, 1);

        // timeout on the TIMEOUT=8 instance
        use_b = 1'b1;
        tgt = '{-1, -1, -1, -1};
        clear_q();
        pulse_start(2'd1, 2'd1);
        wait_idle(100);
        check_res(0, 1, 8, 1);
        check("to_fail_mask", m_fail_mask, 3'b010);
        check("to_all_done", m_all_done, 1);
        tgt = '{3, -1, -1, -1};
        clear_q();
        pulse_start(2'd0, 2'd0);
        @(negedge clk);
        check("to2_fail_clear", m_fail_mask, 0);
        check("to2_all_done_clear", m_all_done, 0);
        wait_idle(100);
        check("to2_count", qp.size(), 1);
        check_res(0, 0, 3, 0);
        check("to2_fail_mask", m_fail_mask, 0);

        check("run_only_when_busy", bad_run, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
